eth_rmii_receiver: RTL and testbench

ETH_RMII_RECEIVER -- requirements
Module: eth_rmii_receiver

---
 rtl/eth_rmii_receiver.sv | 251 +++++++++++++++++++++++++
 tb/tb_eth_rmii_receiver.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rmii_receiver.sv
// RMII receive path: strips preamble/SFD, checks the Ethernet FCS and emits header
// and payload as 32-bit words, withholding the trailing FCS bytes.
module eth_rmii_receiver #(
  parameter int unsigned MAX_PAYLOAD_BYTES = 1460,
  parameter int unsigned HDR_WORDS         = 15
) (
  input  logic        clk_100_mhz,
  input  logic        rst_n,
  input  logic        rx_ce,
  input  logic        crs_dv,
  input  logic [1:0]  rx_d,
  output logic [31:0] out_word,
  output logic [9:0]  out_idx,
  output logic        out_valid,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [2:0]  err_code,
  output logic [10:0] payload_bytes,
  output logic        busy
);
  localparam int unsigned IDX_W = 10;
  localparam int unsigned PAY_W = 11;
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [1:0]  DIB_PRE     = 2'b01;
  localparam logic [1:0]  DIB_SFD     = 2'b11;
  localparam logic [2:0]  PRE_MIN     = 3'd4;
  localparam logic [IDX_W-1:0] TYPE_WORD     = IDX_W'(3);
  localparam logic [IDX_W-1:0] LAST_HDR_WORD = IDX_W'(HDR_WORDS - 1);
  localparam logic [IDX_W-1:0] FIRST_PAY_WORD = IDX_W'(HDR_WORDS);
  localparam logic [PAY_W-1:0] MAX_PAY       = PAY_W'(MAX_PAYLOAD_BYTES);
  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_CRC  = 3'd1;
  localparam logic [2:0] ERR_RUNT = 3'd2;
  localparam logic [2:0] ERR_ALGN = 3'd3;
  localparam logic [2:0] ERR_OVSZ = 3'd4;

  typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, DONE, DROP} state_t;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h0, b};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    return c;
  endfunction

  state_t            state_q, state_d;
  logic              armed_q, armed_d;
  logic [2:0]        pre_cnt_q, pre_cnt_d;
  logic [1:0]        dib_cnt_q, dib_cnt_d;
  logic [5:0]        dib_sr_q, dib_sr_d;
  logic [31:0]       crc_q, crc_d;
  logic [31:0]       dly_q, dly_d;
  logic [2:0]        fill_q, fill_d;
  logic [23:0]       acc_q, acc_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [IDX_W-1:0]  word_idx_q, word_idx_d;
  logic [PAY_W-1:0]  pay_cnt_q, pay_cnt_d;
  logic [2:0]        err_q, err_d;
  logic [31:0]       out_word_q, out_word_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;
  logic              out_valid_q, out_valid_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_ok_q, frame_ok_d;
  logic [2:0]        err_code_q, err_code_d;
  logic [PAY_W-1:0]  payload_bytes_q, payload_bytes_d;
  logic              busy_q, busy_d;
  logic [7:0]        new_byte;
  logic              commit;

  always_ff @(posedge clk_100_mhz) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      armed_q         <= 1'b0;
      pre_cnt_q       <= '0;
      dib_cnt_q       <= '0;
      dib_sr_q        <= '0;
      crc_q           <= CRC_INIT;
      dly_q           <= '0;
      fill_q          <= '0;
      acc_q           <= '0;
      bcnt_q          <= '0;
      word_idx_q      <= '0;
      pay_cnt_q       <= '0;
      err_q           <= ERR_NONE;
      out_word_q      <= '0;
      out_idx_q       <= '0;
      out_valid_q     <= 1'b0;
      frame_done_q    <= 1'b0;
      frame_ok_q      <= 1'b0;
      err_code_q      <= '0;
      payload_bytes_q <= '0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      armed_q         <= armed_d;
      pre_cnt_q       <= pre_cnt_d;
      dib_cnt_q       <= dib_cnt_d;
      dib_sr_q        <= dib_sr_d;
      crc_q           <= crc_d;
      dly_q           <= dly_d;
      fill_q          <= fill_d;
      acc_q           <= acc_d;
      bcnt_q          <= bcnt_d;
      word_idx_q      <= word_idx_d;
      pay_cnt_q       <= pay_cnt_d;
      err_q           <= err_d;
      out_word_q      <= out_word_d;
      out_idx_q       <= out_idx_d;
      out_valid_q     <= out_valid_d;
      frame_done_q    <= frame_done_d;
      frame_ok_q      <= frame_ok_d;
      err_code_q      <= err_code_d;
      payload_bytes_q <= payload_bytes_d;
      busy_q          <= busy_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    armed_d         = armed_q;
    pre_cnt_d       = pre_cnt_q;
    dib_cnt_d       = dib_cnt_q;
    dib_sr_d        = dib_sr_q;
    crc_d           = crc_q;
    dly_d           = dly_q;
    fill_d          = fill_q;
    acc_d           = acc_q;
    bcnt_d          = bcnt_q;
    word_idx_d      = word_idx_q;
    pay_cnt_d       = pay_cnt_q;
    err_d           = err_q;
    out_word_d      = out_word_q;
    out_idx_d       = out_idx_q;
    out_valid_d     = 1'b0;
    frame_done_d    = 1'b0;
    frame_ok_d      = 1'b0;
    err_code_d      = ERR_NONE;
    payload_bytes_d = '0;
    new_byte        = {rx_d, dib_sr_q};
    commit          = 1'b0;

    case (state_q)
      IDLE: if (rx_ce) begin
        // armed only after crs_dv low, so a frame cut by reset is never resynced mid-stream
        if (!crs_dv) armed_d = 1'b1;
        else if (armed_q && rx_d == DIB_PRE) begin
          state_d   = PREAMBLE;
          pre_cnt_d = 3'd1;
        end
      end
      PREAMBLE: if (rx_ce) begin
        if (!crs_dv) state_d = IDLE;
        else if (rx_d == DIB_PRE) begin
          if (pre_cnt_q < PRE_MIN) pre_cnt_d = pre_cnt_q + 3'd1;
        end else if (rx_d == DIB_SFD && pre_cnt_q >= PRE_MIN) begin
          state_d    = HEADER;
          dib_cnt_d  = '0;
          crc_d      = CRC_INIT;
          fill_d     = '0;
          acc_d      = '0;
          bcnt_d     = '0;
          word_idx_d = '0;
          pay_cnt_d  = '0;
          err_d      = ERR_NONE;
        end else begin
          state_d = IDLE;
          armed_d = 1'b0;
        end
      end
      HEADER, PAYLOAD: if (rx_ce) begin
        if (!crs_dv) begin
          state_d = DONE;
          armed_d = 1'b1;
          if (state_q == HEADER)       err_d = ERR_RUNT;
          else if (dib_cnt_q != 2'd0)  err_d = ERR_ALGN;
          else if (crc_q != CRC_RESIDUE) err_d = ERR_CRC;
          else                         err_d = ERR_NONE;
        end else begin
          dib_sr_d  = new_byte[7:2];
          dib_cnt_d = dib_cnt_q + 2'd1;
          if (dib_cnt_q == 2'd3) begin
            // four-byte delay line keeps the FCS from ever being committed
            crc_d = crc_byte(crc_q, new_byte);
            dly_d = {dly_q[23:0], new_byte};
            if (fill_q == 3'd4) commit = 1'b1;
            else fill_d = fill_q + 3'd1;
          end
        end
      end
      DONE: begin
        if (bcnt_q != 2'd0 && word_idx_q >= FIRST_PAY_WORD) begin
          out_valid_d = 1'b1;
          out_idx_d   = word_idx_q;
          bcnt_d      = '0;
          case (bcnt_q)
            2'd1:    out_word_d = {acc_q[7:0], 24'h0};
            2'd2:    out_word_d = {acc_q[15:0], 16'h0};
            default: out_word_d = {acc_q, 8'h0};
          endcase
        end else begin
          state_d         = IDLE;
          frame_done_d    = 1'b1;
          frame_ok_d      = (err_q == ERR_NONE);
          err_code_d      = err_q;
          payload_bytes_d = pay_cnt_q;
        end
      end
      DROP: if (rx_ce && !crs_dv) begin
        state_d         = IDLE;
        armed_d         = 1'b1;
        frame_done_d    = 1'b1;
        err_code_d      = ERR_OVSZ;
        payload_bytes_d = MAX_PAY;
      end
      default: state_d = IDLE;
    endcase

    // pack committed bytes MSB-first; the EtherType word closes after two bytes
    if (commit) begin
      if (state_q == PAYLOAD && pay_cnt_q == MAX_PAY) begin
        state_d = DROP;
      end else begin
        if (state_q == PAYLOAD) pay_cnt_d = pay_cnt_q + PAY_W'(1);
        acc_d  = {acc_q[15:0], dly_q[31:24]};
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3 || (word_idx_q == TYPE_WORD && bcnt_q == 2'd1)) begin
          out_valid_d = 1'b1;
          out_idx_d   = word_idx_q;
          out_word_d  = (word_idx_q == TYPE_WORD) ? {16'h0, acc_q[7:0], dly_q[31:24]}
                                                  : {acc_q, dly_q[31:24]};
          word_idx_d  = word_idx_q + IDX_W'(1);
          bcnt_d      = '0;
          if (word_idx_q == LAST_HDR_WORD) state_d = PAYLOAD;
        end
      end
    end

    busy_d = frame_done_d || (state_d inside {HEADER, PAYLOAD, DONE, DROP});
  end

  assign out_word      = out_word_q;
  assign out_idx       = out_idx_q;
  assign out_valid     = out_valid_q;
  assign frame_done    = frame_done_q;
  assign frame_ok      = frame_ok_q;
  assign err_code      = err_code_q;
  assign payload_bytes = payload_bytes_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_eth_rmii_receiver.sv
// Directed and randomized frames checked against a byte-level model of the receiver.
module tb_eth_rmii_receiver;
  localparam int unsigned MAXP = 1460;

  logic        clk_100_mhz = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_ce = 1'b0;
  logic        crs_dv = 1'b0;
  logic [1:0]  rx_d = 2'b00;
  logic [31:0] out_word;
  logic [9:0]  out_idx;
  logic        out_valid;
  logic        frame_done;
  logic        frame_ok;
  logic [2:0]  err_code;
  logic [10:0] payload_bytes;
  logic        busy;

  eth_rmii_receiver #(.MAX_PAYLOAD_BYTES(MAXP), .HDR_WORDS(15)) dut (
    .clk_100_mhz  (clk_100_mhz),
    .rst_n        (rst_n),
    .rx_ce        (rx_ce),
    .crs_dv       (crs_dv),
    .rx_d         (rx_d),
    .out_word     (out_word),
    .out_idx      (out_idx),
    .out_valid    (out_valid),
    .frame_done   (frame_done),
    .frame_ok     (frame_ok),
    .err_code     (err_code),
    .payload_bytes(payload_bytes),
    .busy         (busy)
  );

  always #5 clk_100_mhz = ~clk_100_mhz;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  tx_q[$];
  logic [41:0] exp_q[$];
  int          exp_err;
  logic [10:0] exp_pay;

  // output monitor
  logic [41:0] got_q[$];
  int          done_cnt = 0;
  int          words_at_done = 0;
  logic        got_ok = 1'b0;
  logic [2:0]  got_err = 3'd0;
  logic [10:0] got_pay = 11'd0;
  logic        busy_at_done = 1'b0;
  logic        busy_after = 1'b1;
  logic        busy_pend = 1'b0;

  always @(negedge clk_100_mhz) begin
    if (busy_pend) begin
      busy_after = busy;
      busy_pend  = 1'b0;
    end
    if (out_valid) got_q.push_back({out_idx, out_word});
    if (frame_done) begin
      done_cnt++;
      words_at_done = got_q.size();
      got_ok        = frame_ok;
      got_err       = err_code;
      got_pay       = payload_bytes;
      busy_at_done  = busy;
      busy_pend     = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100_mhz);
    #1;
  endtask

  task automatic send_dibit(input logic cd, input logic [1:0] d);
    rx_ce = 1'b1; crs_dv = cd; rx_d = d;
    tick();
    rx_ce = 1'b0;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 4; i++) send_dibit(1'b1, b[2*i +: 2]);
  endtask

  function automatic logic [31:0] fcs_of(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, tx_q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic start_frame();
    tx_q.delete();
    for (int i = 0; i < 58; i++) tx_q.push_back(8'($urandom));
  endtask

  task automatic finish_frame();
    logic [31:0] c;
    c = fcs_of(tx_q.size());
    for (int i = 0; i < 4; i++) tx_q.push_back(c[8*i +: 8]);
  endtask

  // Expected words/status for the first ndib dibits of tx_q after SFD
  task automatic build_expect(input int ndib);
    int nb, rem, comm, hdr, npay, lo, len;
    bit over, crc_ok;
    logic [31:0] w;
    nb = ndib / 4; rem = ndib % 4;
    comm = (nb > 4) ? nb - 4 : 0;
    hdr = (comm > 58) ? 58 : comm;
    npay = 0; over = 0;
    exp_q.delete();
    for (int k = 0; k < 15; k++) begin
      lo  = (k < 3) ? 4*k : (k == 3) ? 12 : 14 + 4*(k-4);
      len = (k == 3) ? 2 : 4;
      if (hdr >= lo + len) begin
        w = '0;
        for (int b = 0; b < len; b++) w = {w[23:0], tx_q[lo+b]};
        exp_q.push_back({10'(k), w});
      end
    end
    if (nb < 62) exp_err = 2;
    else begin
      npay = comm - 58;
      if (npay > int'(MAXP)) begin
        over = 1; npay = MAXP; exp_err = 4;
      end else begin
        crc_ok = (fcs_of(nb-4) == {tx_q[nb-1], tx_q[nb-2], tx_q[nb-3], tx_q[nb-4]});
        exp_err = (rem != 0) ? 3 : crc_ok ? 0 : 1;
      end
      for (int j = 0; j < npay; j += 4) begin
        if (npay - j >= 4 || !over) begin
          w = '0;
          for (int b = 0; b < 4; b++) w = {w[23:0], (j+b < npay) ? tx_q[58+j+b] : 8'h00};
          exp_q.push_back({10'(15 + j/4), w});
        end
      end
    end
    exp_pay = 11'(npay);
  endtask

  task automatic send_frame(input int ndib, input int rst_at);
    logic [7:0] b;
    repeat (6) send_dibit(1'b0, 2'b00);
    repeat (7) send_byte(8'h55);
    send_byte(8'hD5);
    for (int i = 0; i < ndib; i++) begin
      b = tx_q[i/4];
      send_dibit(1'b1, b[2*(i%4) +: 2]);
      if (i == rst_at) begin
        rst_n = 1'b0;
        tick();
        check("mid_rst outputs", {out_word, out_idx, out_valid, frame_done, frame_ok,
                                  err_code, payload_bytes, busy}, 64'h0);
        rst_n = 1'b1;
      end
    end
    repeat (10) send_dibit(1'b0, 2'b00);
  endtask

  task automatic run_frame(input string tag, input int ndib);
    int wbase, dbase, waited, n;
    wbase = got_q.size(); dbase = done_cnt; waited = 0;
    build_expect(ndib);
    send_frame(ndib, -1);
    while (done_cnt == dbase && waited < 200) begin
      tick();
      waited++;
    end
    check({tag, " done"}, 64'(done_cnt - dbase), 64'd1);
    check({tag, " ok"}, 64'(got_ok), 64'(exp_err == 0));
    check({tag, " err"}, 64'(got_err), 64'(exp_err));
    check({tag, " pay"}, 64'(got_pay), 64'(exp_pay));
    check({tag, " nwords"}, 64'(got_q.size() - wbase), 64'(exp_q.size()));
    check({tag, " words_before_done"}, 64'(words_at_done - wbase), 64'(exp_q.size()));
    check({tag, " busy_at_done"}, 64'(busy_at_done), 64'd1);
    check({tag, " busy_after"}, 64'(busy_after), 64'd0);
    n = got_q.size() - wbase;
    if (n > exp_q.size()) n = exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s word%0d", tag, i), 64'(got_q[wbase+i]), 64'(exp_q[i]));
  endtask

  initial begin
    int dbase, np, nd;
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset outputs", {out_word, out_idx, out_valid, frame_done, frame_ok,
                            err_code, payload_bytes, busy}, 64'h0);
    rst_n = 1'b1;
    tick();

    start_frame();
    for (int i = 1; i <= 8; i++) tx_q.push_back(8'(i));
    finish_frame();
    run_frame("good8", 4*tx_q.size());
    check("good8 w15", 64'(exp_q[15][31:0]), 64'h01020304);

    start_frame();
    tx_q.push_back(8'hAA); tx_q.push_back(8'hBB); tx_q.push_back(8'hCC);
    finish_frame();
    run_frame("good3", 4*tx_q.size());

    start_frame();
    for (int i = 1; i <= 8; i++) tx_q.push_back(8'(i));
    finish_frame();
    tx_q[61] = tx_q[61] ^ 8'h08;
    run_frame("crcbad", 4*tx_q.size());

    start_frame();
    for (int i = 1; i <= 8; i++) tx_q.push_back(8'(i));
    finish_frame();
    run_frame("runt20", 80);

    start_frame();
    for (int i = 0; i < 10; i++) tx_q.push_back(8'($urandom));
    finish_frame();
    run_frame("align", 4*(58+5) + 2);

    start_frame();
    for (int i = 0; i < 1500; i++) tx_q.push_back(8'($urandom));
    finish_frame();
    run_frame("oversize", 4*tx_q.size());

    start_frame();
    for (int i = 0; i < 20; i++) tx_q.push_back(8'($urandom));
    finish_frame();
    dbase = done_cnt;
    send_frame(4*tx_q.size(), 4*(58+6));
    repeat (20) tick();
    check("mid_rst no_done", 64'(done_cnt - dbase), 64'd0);

    start_frame();
    for (int i = 0; i < 12; i++) tx_q.push_back(8'($urandom));
    finish_frame();
    run_frame("after_rst", 4*tx_q.size());

    for (int f = 0; f < 8; f++) begin
      np = $urandom_range(0, 48);
      start_frame();
      for (int i = 0; i < np; i++) tx_q.push_back(8'($urandom));
      finish_frame();
      if ($urandom_range(0, 1) == 1)
        tx_q[$urandom_range(0, tx_q.size()-1)] ^= 8'(1 << $urandom_range(0, 7));
      nd = 4*tx_q.size();
      if ($urandom_range(0, 3) == 0) nd = $urandom_range(4*62, nd - 1);
      run_frame($sformatf("rnd%0d", f), nd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
